// File: rtl/vga_frame_scanner_if.sv
// vga_frame_scanner_if: pixel coordinates, mux colour and VGA pin bundle
// between the object mux and the display scanner.
interface vga_frame_scanner_if;
  logic [7:0]  redIn;
  logic [7:0]  greenIn;
  logic [7:0]  blueIn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        pixelTick;
  logic        startOfFrame;
  logic [7:0]  vgaR;
  logic [7:0]  vgaG;
  logic [7:0]  vgaB;
  logic        vgaHS;
  logic        vgaVS;
  logic        vgaBlankN;

  modport master (
    input  redIn, greenIn, blueIn,
    output pixelX, pixelY, pixelTick, startOfFrame,
    output vgaR, vgaG, vgaB, vgaHS, vgaVS, vgaBlankN
  );

  modport slave (
    output redIn, greenIn, blueIn,
    input  pixelX, pixelY, pixelTick, startOfFrame,
    input  vgaR, vgaG, vgaB, vgaHS, vgaVS, vgaBlankN
  );
endinterface

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: VGA raster timing, coordinate publish and
// sync/blank-aligned colour register toward the DAC pins.
module vga_frame_scanner #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input logic clk,
  input logic resetN,
  vga_frame_scanner_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_E_ACT = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_E_FP  = 11'(H_ACTIVE + H_FP - 1);
  localparam logic [10:0] H_E_SY  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_E_ACT = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_E_FP  = 11'(V_ACTIVE + V_FP - 1);
  localparam logic [10:0] V_E_SY  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    H_ACT, H_FRONT, H_SYNCP, H_BACK
  } hphase_t;

  typedef enum logic [1:0] {
    V_ACT, V_FRONT, V_SYNCP, V_BACK
  } vphase_t;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] divNext;
  logic             tick;
  logic [10:0]      hCount;
  logic [10:0]      vCount;
  logic             hWrap;
  logic             vWrap;
  hphase_t          hState;
  hphase_t          hNext;
  vphase_t          vState;
  vphase_t          vNext;
  logic             frameWrap;
  logic             sof;
  logic [2:0]       raw;
  logic [2:0]       tap;
  logic [7:0]       r;
  logic [7:0]       g;
  logic [7:0]       b;
  logic             hs;
  logic             vs;
  logic             blankN;

  assign divNext = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  assign hWrap = (hCount == H_LAST);
  assign vWrap = (vCount == V_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      div  <= divNext;
      tick <= (divNext == DIV_LAST);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCount <= '0;
      vCount <= '0;
    end else if (tick) begin
      if (hWrap) begin
        hCount <= '0;
        vCount <= vWrap ? '0 : vCount + 11'd1;
      end else begin
        hCount <= hCount + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hState <= H_ACT;
      vState <= V_ACT;
    end else begin
      hState <= hNext;
      vState <= vNext;
    end
  end

  // Phase registers change on the same tick as the counter crosses a boundary
  always_comb begin
    hNext = hState;
    unique case (hState)
      H_ACT:   if (tick && hCount == H_E_ACT) hNext = H_FRONT;
      H_FRONT: if (tick && hCount == H_E_FP)  hNext = H_SYNCP;
      H_SYNCP: if (tick && hCount == H_E_SY)  hNext = H_BACK;
      H_BACK:  if (tick && hWrap)             hNext = H_ACT;
      default: hNext = H_ACT;
    endcase
  end

  always_comb begin
    vNext = vState;
    if (tick && hWrap) begin
      unique case (vState)
        V_ACT:   if (vCount == V_E_ACT) vNext = V_FRONT;
        V_FRONT: if (vCount == V_E_FP)  vNext = V_SYNCP;
        V_SYNCP: if (vCount == V_E_SY)  vNext = V_BACK;
        V_BACK:  if (vWrap)             vNext = V_ACT;
        default: vNext = V_ACT;
      endcase
    end
  end

  assign raw = {hState != H_SYNCP,
                vState != V_SYNCP,
                hState == H_ACT && vState == V_ACT};

  // Output register is the final delay stage; extra stages only when deeper
  generate
    if (PIPE_DELAY > 1) begin : g_dly
      localparam logic [2:0] IDLE = 3'b110;
      logic [2:0] dly [PIPE_DELAY-1];
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < PIPE_DELAY - 1; i++) dly[i] <= IDLE;
        end else if (tick) begin
          dly[0] <= raw;
          for (int i = 1; i < PIPE_DELAY - 1; i++) dly[i] <= dly[i-1];
        end
      end
      assign tap = dly[PIPE_DELAY-2];
    end else begin : g_nodly
      assign tap = raw;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hs        <= 1'b1;
      vs        <= 1'b1;
      blankN    <= 1'b0;
      frameWrap <= 1'b0;
      sof       <= 1'b0;
    end else begin
      frameWrap <= tick && hWrap && vWrap;
      sof       <= frameWrap;
      if (tick) begin
        hs     <= tap[2];
        vs     <= tap[1];
        blankN <= tap[0];
        r      <= tap[0] ? vga.redIn   : 8'd0;
        g      <= tap[0] ? vga.greenIn : 8'd0;
        b      <= tap[0] ? vga.blueIn  : 8'd0;
      end
    end
  end

  assign vga.pixelX       = hCount;
  assign vga.pixelY       = vCount;
  assign vga.pixelTick    = tick;
  assign vga.startOfFrame = sof;
  assign vga.vgaR         = r;
  assign vga.vgaG         = g;
  assign vga.vgaB         = b;
  assign vga.vgaHS        = hs;
  assign vga.vgaVS        = vs;
  assign vga.vgaBlankN    = blankN;
endmodule
